// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer sizing, Gray conversion, almost-full compare.
// Imported by both the write-side and read-side controllers.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic wr_ovf;
  } wr_flags_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  // Operates on a 32-bit carrier; callers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic af_hit(input int unsigned level, input int unsigned depth,
                                  input int unsigned margin);
    return level >= (depth - margin);
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer-side bundle of the write controller; WR_LEVEL_EN adds the wr_level output.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rdptr_sync;
  logic                  ovf_clr;
  logic                  wclken;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic                  wr_ovf;
`ifdef WR_LEVEL_EN
  logic [ADDR_WIDTH:0]   wr_level;
`endif

  modport master (
    output wr_en, rdptr_sync, ovf_clr,
`ifdef WR_LEVEL_EN
    input  wr_level,
`endif
    input  wclken, waddr, wptr_gray, full, almost_full, wr_ovf
  );

  modport slave (
    input  wr_en, rdptr_sync, ovf_clr,
`ifdef WR_LEVEL_EN
    output wr_level,
`endif
    output wclken, waddr, wptr_gray, full, almost_full, wr_ovf
  );
endinterface

// File: rtl/fifo_gray2bin.sv
// Gray to binary conversion as an XOR prefix from the MSB; purely combinational.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: write pointer (bin+Gray), RAM strobe, full/almost_full/overflow.
// Optional WR_LEVEL_EN macro exports the registered fill level as wr_level.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input logic           wr_clk,
  input logic           wr_rst_n,
  fifo_wr_ctrl_if.slave bus
);
  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] rbin, level_d, full_tgt;
  wr_flags_t        flags_q, flags_d;
  logic             accept, overflow;

  fifo_gray2bin #(.W(PTR_W)) u_rd_g2b (
    .gray_i (bus.rdptr_sync),
    .bin_o  (rbin)
  );

  assign accept   = bus.wr_en & ~flags_q.full;
  assign overflow = bus.wr_en & flags_q.full;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_tgt = {~bus.rdptr_sync[PTR_W-1 -: 2], bus.rdptr_sync[PTR_W-3:0]};

  always_comb begin
    wbin_d              = accept ? wbin_q + PTR_W'(1) : wbin_q;
    wgray_d             = PTR_W'(bin2gray(32'(wbin_d)));
    level_d             = wbin_d - rbin;
    flags_d             = '0;
    flags_d.full        = (wgray_d == full_tgt);
    flags_d.almost_full = af_hit(32'(level_d), DEPTH, AF_MARGIN);
    flags_d.wr_ovf      = overflow | (flags_q.wr_ovf & ~bus.ovf_clr);
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      flags_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      flags_q <= flags_d;
    end
  end

`ifdef WR_LEVEL_EN
  logic [PTR_W-1:0] level_q;

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) level_q <= '0;
    else           level_q <= level_d;
  end

  assign bus.wr_level = level_q;
`endif

  assign bus.wclken      = accept;
  assign bus.waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray   = wgray_q;
  assign bus.full        = flags_q.full;
  assign bus.almost_full = flags_q.almost_full;
  assign bus.wr_ovf      = flags_q.wr_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (ADDR_WIDTH=4, AF_MARGIN=2): scoreboard of expected write addresses
// plus a level-based reference model for the status flags.
module tb_fifo_wr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
    .wr_clk   (clk),
    .wr_rst_n (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  int m_wbin = 0;
  int m_rbin = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ovf  = 1'b0;

  bit         ea;
  logic       se;
  logic [3:0] sa;
  logic [3:0] exp_a;

  task automatic set_rd(input int r);
    m_rbin = r % 32;
    bus.rdptr_sync = 5'(m_rbin ^ (m_rbin >> 1));
  endtask

  // One clock: drive wr_en, capture comb outputs at negedge, advance the model at posedge.
  task automatic step(input bit en, output bit acc, output logic s_en, output logic [3:0] s_addr);
    bus.wr_en = en;
    acc = en && rst_n && !m_full;
    if (acc) exp_q.push_back(4'(m_wbin));
    @(negedge clk);
    s_en   = bus.wclken;
    s_addr = bus.waddr;
    @(posedge clk);
    if (!rst_n) begin
      m_wbin = 0; m_ovf = 1'b0; m_lvl = 0;
      exp_q.delete();
    end else begin
      if (en && m_full) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      if (acc) m_wbin = (m_wbin + 1) % 32;
      m_lvl = (m_wbin - m_rbin + 32) % 32;
    end
    m_full = (m_lvl == 16);
    m_af   = (m_lvl >= 14);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.ovf_clr = 1'b0; set_rd(0);
    repeat (2) step(1'b1, ea, se, sa);
    total++; if (bus.wptr_gray !== 5'b00000) begin bad++; $display("FAIL reset_wptr_gray got=%b want=00000", bus.wptr_gray); end
    total++; if (bus.waddr !== 4'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", bus.waddr); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
    total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b want=0", bus.almost_full); end
    total++; if (bus.wr_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.wr_ovf); end
`ifdef WR_LEVEL_EN
    total++; if (bus.wr_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.wr_level); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, ea, se, sa);
      total++; if (se !== 1'b1) begin bad++; $display("FAIL fill_wclken i=%0d got=%b want=1", i, se); end
      if (se === 1'b1 && exp_q.size() > 0) begin
        exp_a = exp_q.pop_front();
        total++; if (sa !== exp_a) begin bad++; $display("FAIL fill_waddr i=%0d got=%0d want=%0d", i, sa, exp_a); end
      end
      total++; if (bus.almost_full !== (i >= 13)) begin bad++; $display("FAIL fill_af i=%0d got=%b want=%b", i, bus.almost_full, i >= 13); end
      total++; if (bus.full !== (i == 15)) begin bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, bus.full, i == 15); end
`ifdef WR_LEVEL_EN
      total++; if (bus.wr_level !== 5'(i + 1)) begin bad++; $display("FAIL fill_level i=%0d got=%0d want=%0d", i, bus.wr_level, i + 1); end
`endif
    end
    total++; if (bus.wptr_gray !== 5'b11000) begin bad++; $display("FAIL fill_wptr_gray got=%b want=11000", bus.wptr_gray); end
  endtask

  task automatic test_overflow();
    step(1'b1, ea, se, sa);
    total++; if (se !== 1'b0) begin bad++; $display("FAIL ovf_wclken got=%b want=0", se); end
    total++; if (bus.wptr_gray !== 5'b11000) begin bad++; $display("FAIL ovf_wptr_gray got=%b want=11000", bus.wptr_gray); end
    total++; if (bus.wr_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", bus.wr_ovf); end
    bus.ovf_clr = 1'b1;
    step(1'b1, ea, se, sa);
    total++; if (bus.wr_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", bus.wr_ovf); end
    step(1'b0, ea, se, sa);
    total++; if (bus.wr_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", bus.wr_ovf); end
    bus.ovf_clr = 1'b0;
    step(1'b0, ea, se, sa);
    total++; if (bus.wr_ovf !== m_ovf) begin bad++; $display("FAIL ovf_stays_clear got=%b want=%b", bus.wr_ovf, m_ovf); end
  endtask

  task automatic test_free();
    set_rd(1);
    step(1'b0, ea, se, sa);
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL free_full got=%b want=0", bus.full); end
    total++; if (bus.almost_full !== 1'b1) begin bad++; $display("FAIL free_af got=%b want=1", bus.almost_full); end
    step(1'b1, ea, se, sa);
    total++; if (se !== 1'b1) begin bad++; $display("FAIL free_wclken got=%b want=1", se); end
    if (exp_q.size() > 0) begin
      exp_a = exp_q.pop_front();
      total++; if (sa !== exp_a || sa !== 4'd0) begin bad++; $display("FAIL free_waddr got=%0d want=%0d", sa, exp_a); end
    end
    total++; if (bus.full !== m_full) begin bad++; $display("FAIL free_refull got=%b want=%b", bus.full, m_full); end
  endtask

  task automatic test_wrap();
    int written;
    rst_n = 1'b0; set_rd(0);
    step(1'b0, ea, se, sa);
    rst_n = 1'b1;
    written = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ea, se, sa);
      total++; if (se !== 1'b1) begin bad++; $display("FAIL wrap_wclken i=%0d got=%b want=1", i, se); end
      if (se === 1'b1 && exp_q.size() > 0) begin
        exp_a = exp_q.pop_front();
        total++; if (sa !== exp_a) begin bad++; $display("FAIL wrap_waddr i=%0d got=%0d want=%0d", i, sa, exp_a); end
      end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL wrap_full i=%0d got=%b want=0", i, bus.full); end
      total++; if (bus.almost_full !== m_af) begin bad++; $display("FAIL wrap_af i=%0d got=%b want=%b", i, bus.almost_full, m_af); end
`ifdef WR_LEVEL_EN
      total++; if (bus.wr_level > 5'd4 || bus.wr_level !== 5'(m_lvl)) begin bad++; $display("FAIL wrap_level i=%0d got=%0d want=%0d", i, bus.wr_level, m_lvl); end
`endif
      written++;
      set_rd(written > 3 ? written - 3 : 0);
    end
    total++; if (bus.wptr_gray !== 5'b01100) begin bad++; $display("FAIL wrap_wptr_gray got=%b want=01100", bus.wptr_gray); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; set_rd(0);
    step(1'b0, ea, se, sa);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, ea, se, sa);
      if (exp_q.size() > 0) begin
        exp_a = exp_q.pop_front();
        total++; if (sa !== exp_a) begin bad++; $display("FAIL mid_waddr i=%0d got=%0d want=%0d", i, sa, exp_a); end
      end
    end
    rst_n = 1'b0;
    step(1'b0, ea, se, sa);
    total++; if (bus.wptr_gray !== 5'b00000) begin bad++; $display("FAIL mid_wptr_gray got=%b want=00000", bus.wptr_gray); end
    total++; if (bus.waddr !== 4'd0) begin bad++; $display("FAIL mid_waddr_rst got=%0d want=0", bus.waddr); end
    total++; if ({bus.full, bus.almost_full, bus.wr_ovf} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b want=000", {bus.full, bus.almost_full, bus.wr_ovf}); end
    rst_n = 1'b1;
    step(1'b1, ea, se, sa);
    total++; if (se !== 1'b1 || sa !== 4'd0) begin bad++; $display("FAIL mid_first_write en=%b addr=%0d want en=1 addr=0", se, sa); end
    if (exp_q.size() > 0) exp_a = exp_q.pop_front();
    total++; if (bus.wptr_gray !== 5'b00001) begin bad++; $display("FAIL mid_wptr_after got=%b want=00001", bus.wptr_gray); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rdptr_sync = 5'b00000;
    test_reset();
    test_fill();
    test_overflow();
    test_free();
    test_wrap();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
